mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter INPUTS, default 4: number of requesters sharing one mux output, range 2..16.
REQ-002 Parameter INPUTS_WIDTH, default 2: width of select; SHALL satisfy 2**INPUTS_WIDTH >= INPUTS.
REQ-003 Parameter MAX_HOLD, default 8: max consecutive granted cycles before forced rotation; 0 = never preempt; range 0..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  INPUTS  per-requester request level; bit i held high for the duration of requester i's burst.
REQ-007 grant  output  INPUTS  registered one-hot grant; all-zero when idle.
REQ-008 select  output  INPUTS_WIDTH  registered binary index of the granted requester; drives the mux select directly.
REQ-009 active  output  1  registered; high iff grant is non-zero.

Function
REQ-010 Two states: IDLE (grant=0) and GRANT (exactly one grant bit set); no other state reachable.
REQ-011 Round-robin pointer ptr (INPUTS_WIDTH bits) = index last granted + 1, wrapping from INPUTS-1 to 0; the winner is the first set req bit scanning ptr, ptr+1, ... modulo INPUTS.
REQ-012 IDLE, req != 0 at edge N: grant/select/active reflect the winner from cycle N+1; state -> GRANT; hold counter -> 0.
REQ-013 IDLE, req == 0: remain IDLE; outputs unchanged.
REQ-014 GRANT, req[select] == 0 (release): same edge re-arbitrates among remaining requests; winner granted next cycle with hold counter 0; if none, -> IDLE, grant=0, active=0.
REQ-015 GRANT, req[select] == 1, MAX_HOLD != 0, hold counter == MAX_HOLD-1, another req bit set: preempt; grant the next winner by REQ-011 excluding current index; hold counter -> 0.
REQ-016 GRANT, req[select] == 1, no preemption: grant unchanged; hold counter increments, saturating at MAX_HOLD-1 (at 0 when MAX_HOLD == 0).
REQ-017 No cycle with two grant bits set; handoff between requesters has zero idle cycles.
REQ-018 select retains the last granted index while IDLE, so the mux output stays stable.
REQ-019 req bits at index >= INPUTS do not exist; pointer arithmetic never yields an index >= INPUTS.
REQ-020 Requests asserting/deasserting on the same edge as a grant change are sampled at that edge only; no combinational req-to-grant path.
REQ-021 ptr updates only when a new grant is issued (REQ-012/014/015).

Reset
REQ-022 reset_n low SHALL immediately force grant=0, select=0, active=0, state IDLE, hold counter=0, ptr=0, regardless of clk.
REQ-023 Reset asserted mid-burst: grant drops asynchronously; after release, arbitration restarts from ptr=0 on the first edge.
REQ-024 Reset deassertion alone causes no grant; first grant requires a sampled req at a subsequent edge.

Verification
REQ-025 Reset, req=4'b0000 for 5 cycles -> grant=0, select=0, active=0 throughout.
REQ-026 From reset, req=4'b1010 at edge 1 -> grant=4'b0010, select=1 at cycle 2; drop req[1] at edge 4 -> grant=4'b1000, select=3 at cycle 5, no gap cycle.
REQ-027 MAX_HOLD=8, req=4'b0011 held constant -> grant alternates 0001/0010 every 8 cycles; req=4'b0001 alone -> grant=0001 held indefinitely.
REQ-028 All four requesting, each releasing after 1 granted cycle -> grant order 0,1,2,3,0 with ptr wrap 3->0.
REQ-029 Assert reset_n=0 between clock edges while grant=4'b0100 -> grant=0, select=0 before next edge; after release with req=4'b0100 -> grant=0100 one cycle after first sampled edge.
REQ-030 Randomised req for 10k cycles -> assertions: grant one-hot-or-zero, active == |grant, grant[select] when active, no requester waits longer than (INPUTS-1)*MAX_HOLD cycles when MAX_HOLD != 0.

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin arbiter that drives a shared mux select, with an optional hold limit
// that forces rotation when other requesters are waiting.
module mux_arbiter #(
  parameter int INPUTS       = 4,
  parameter int INPUTS_WIDTH = 2,
  parameter int MAX_HOLD     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [INPUTS-1:0]       req,
  output logic [INPUTS-1:0]       grant,
  output logic [INPUTS_WIDTH-1:0] select,
  output logic                    active
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [INPUTS_WIDTH-1:0] LAST_IDX = INPUTS_WIDTH'(INPUTS - 1);

  state_t                  state_q, state_d;
  logic [INPUTS-1:0]       grant_q, grant_d;
  logic [INPUTS_WIDTH-1:0] select_q, select_d;
  logic                    active_q, active_d;
  logic [7:0]              hold_q, hold_d;
  logic [INPUTS_WIDTH-1:0] ptr_q, ptr_d;

  logic [INPUTS-1:0]       cand;
  logic                    cur_req;
  logic                    win_found;
  logic [INPUTS_WIDTH-1:0] win_idx;
  logic                    new_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= '0;
      active_q <= 1'b0;
      hold_q   <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      active_q <= active_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
    end
  end

  // Masking the current owner makes the same scan serve idle, release and preemption.
  always_comb begin : arb
    logic [2*INPUTS-1:0] rot;
    int                  sum;
    cand      = req & ~grant_q;
    rot       = {cand, cand} >> ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = 0;
    for (int k = 0; k < INPUTS; k++) begin
      if (!win_found && rot[0]) begin
        win_found = 1'b1;
        sum       = int'(ptr_q) + k;
        if (sum >= INPUTS) sum -= INPUTS;
        win_idx   = INPUTS_WIDTH'(sum);
      end
      rot = rot >> 1;
    end
  end

  assign cur_req = |(req & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    select_d  = select_q;
    active_d  = active_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) new_grant = 1'b1;
      end
      GRANT: begin
        if (!cur_req) begin
          if (win_found) begin
            new_grant = 1'b1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            active_d = 1'b0;
            hold_d   = '0;
          end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST && win_found) begin
          new_grant = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // select is left untouched on the way to IDLE so the mux output stays put.
    if (new_grant) begin
      state_d  = GRANT;
      grant_d  = INPUTS'(1) << win_idx;
      select_d = win_idx;
      active_d = 1'b1;
      hold_d   = '0;
      ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    grant  = grant_q;
    select = select_q;
    active = active_q;
  end

endmodule
